lsu_mem_if: RTL and testbench

- Multi-cycle load/store unit between the RV32I datapath and a handshaked data-memory bus.
- Consumes the register file's store operand (rd2) and the ALU address. Produces the sign- or zero-extended load result that feeds the register file's write port (wd3/we3).
- Stalls the core through `busy` while a bus transaction is in flight.

---
 rtl/lsu_mem_if.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: multi-cycle RV32I load/store unit between the core datapath and a
// handshaked data-memory bus. Stalls the core via busy while a bus access is in
// flight and returns sign/zero-extended load data toward the register file.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are trapped (err=1, misalign=1) without touching the bus;
// when undefined the offending low address bits are ignored.
module lsu_mem_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        rd_we,
    output logic [31:0] rdata_wb,
    output logic        err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the counter during the last ACCESS cycle before the abort.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           write_q;
    logic [2:0]     f3_q;
    logic [1:0]     alo_q;
    logic           mem_req_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [3:0]     mem_be_q;
    logic [31:0]    mem_wdata_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic           legal_w;
    logic           trap_w;
    logic           start_bus_w;

    // Loads: LB LH LW LBU LHU. Stores: SB SH SW.
    function automatic logic is_legal(input logic wr, input logic [2:0] f3);
        if (wr) begin
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Byte enables for a store; size code is funct3[1:0].
    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables pick the target.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Lane selection plus sign/zero extension of the returned bus word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    assign trap_w   = legal_w & is_misaligned(funct3[1:0], addr[1:0]);
    assign misalign = misalign_q;
`else
    assign trap_w   = 1'b0;
    assign misalign = 1'b0;
`endif

    assign legal_w     = is_legal(req_write, funct3);
    assign start_bus_w = legal_w & ~trap_w;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the final ACCESS cycle still counts as success
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = start_bus_w ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Core-facing handshake outputs decoded from state
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_we = 1'b0;
        case (state_q)
            S_IDLE:   busy = req_valid;
            S_ACCESS: busy = 1'b1;
            S_RESP: begin
                done  = 1'b1;
                rd_we = ~write_q & ~err_q;
            end
            default: ;
        endcase
    end

    // Timeout counter runs only while waiting in ACCESS
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_ACCESS) && !mem_ack && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Request capture, bus drive and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            f3_q        <= 3'b000;
            alo_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        f3_q    <= funct3;
                        alo_q   <= addr[1:0];
                        rdata_q <= '0;
                        err_q   <= ~legal_w | trap_w;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_q <= trap_w;
`endif
                        if (start_bus_w) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= req_write ? store_be(funct3[1:0], addr[1:0]) : 4'b1111;
                            mem_wdata_q <= req_write ? store_lanes(funct3[1:0], wdata) : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b0;
                        rdata_q   <= write_q ? '0 : load_extend(f3_q, alo_q, mem_rdata);
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata_wb  = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed bench for lsu_mem_if with a transaction-level
// reference model and a per-cycle compare process.
module tb_lsu_mem_if;

    localparam int TO = 4;

    localparam int S_BUSY   = 0;
    localparam int S_DONE   = 1;
    localparam int S_RDWE   = 2;
    localparam int S_ERR    = 3;
    localparam int S_MIS    = 4;
    localparam int S_MREQ   = 5;
    localparam int S_MWE    = 6;
    localparam int S_MADDR  = 7;
    localparam int S_MBE    = 8;
    localparam int S_MWDATA = 9;
    localparam int S_RDATA  = 10;
    localparam int NSIG     = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        rd_we;
    logic [31:0] rdata_wb;
    logic        err;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rd_we     (rd_we),
        .rdata_wb  (rdata_wb),
        .err       (err),
        .misalign  (misalign),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations written by the stimulus, read by the compare process.
    bit          exp_chk [NSIG];
    logic [31:0] exp_val [NSIG];
    int          pin_cnt;
    string       pin_nm  [4];
    int          pin_sel [4];
    logic [31:0] pin_exp [4];
    int          n_vec = 0;
    int          n_mis = 0;

    function automatic logic [31:0] dut_sig(input int s);
        case (s)
            S_BUSY:   return {31'b0, busy};
            S_DONE:   return {31'b0, done};
            S_RDWE:   return {31'b0, rd_we};
            S_ERR:    return {31'b0, err};
            S_MIS:    return {31'b0, misalign};
            S_MREQ:   return {31'b0, mem_req};
            S_MWE:    return {31'b0, mem_we};
            S_MADDR:  return mem_addr;
            S_MBE:    return {28'b0, mem_be};
            S_MWDATA: return mem_wdata;
            default:  return rdata_wb;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_BUSY:   return "busy";
            S_DONE:   return "done";
            S_RDWE:   return "rd_we";
            S_ERR:    return "err";
            S_MIS:    return "misalign";
            S_MREQ:   return "mem_req";
            S_MWE:    return "mem_we";
            S_MADDR:  return "mem_addr";
            S_MBE:    return "mem_be";
            S_MWDATA: return "mem_wdata";
            default:  return "rdata_wb";
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s at t=%0t: got 0x%08h, want 0x%08h", nm, $time, act, expv);
        end
    endtask

    // Compare process: checks every armed expectation away from the active edge
    always @(negedge clk) begin
        for (int s = 0; s < NSIG; s++) begin
            if (exp_chk[s]) cmp(sig_name(s), dut_sig(s), exp_val[s]);
        end
        for (int p = 0; p < pin_cnt; p++) begin
            cmp({"pinned ", pin_nm[p]}, dut_sig(pin_sel[p]), pin_exp[p]);
        end
    end

    // ---------------- reference model (specification rules) ----------------
    function automatic bit m_legal(input bit w, input logic [2:0] f3);
        if (w) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'd0;
        return 1'b0;
`else
        return (f3 == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input bit w, input logic [2:0] f3, input logic [31:0] a);
        if (!w) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << int'(a[1:0]));
        if (f3 == 3'd1) return 4'(3 << (2 * int'(a[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return 32'(d[7:0]) * 32'h0101_0101;
        if (f3 == 3'd1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        int          sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = 8 * int'(a[1:0]);
                v  = (w >> sh) & 32'h0000_00FF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                sh = 16 * int'(a[1]);
                v  = (w >> sh) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        for (int s = 0; s < NSIG; s++) exp_chk[s] = 1'b0;
        pin_cnt = 0;
    endtask

    task automatic expect_sig(input int s, input logic [31:0] v);
        exp_chk[s] = 1'b1;
        exp_val[s] = v;
    endtask

    task automatic pin(input string nm, input int s, input logic [31:0] v);
        if (pin_cnt < 4) begin
            pin_nm[pin_cnt]  = nm;
            pin_sel[pin_cnt] = s;
            pin_exp[pin_cnt] = v;
            pin_cnt++;
        end
    endtask

    // One full request: accept, ACCESS (ack after ack_at waits, -1 = never), RESP, idle.
    task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int ack_at, input logic [31:0] rd,
                       input bit pin_on, input logic [31:0] p_addr, input logic [3:0] p_be,
                       input logic [31:0] p_wdata, input logic [31:0] p_rdata);
        bit mis;
        bit bus;
        bit acked;
        bit e;
        mis   = m_legal(w, f3) && m_mis(f3, a);
        bus   = m_legal(w, f3) && !mis;
        acked = 1'b0;
        // accept cycle; a stray ack while idle must be ignored
        req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = d;
        mem_ack = 1'b1; mem_rdata = $urandom;
        expect_sig(S_BUSY, 1); expect_sig(S_DONE, 0); expect_sig(S_RDWE, 0); expect_sig(S_MREQ, 0);
        step();
        // scramble request inputs: the unit must work from its latched copy
        req_valid = 1'b0; req_write = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        if (bus) begin
            for (int k = 0; k < TO; k++) begin
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rd : $urandom;
                expect_sig(S_BUSY, 1); expect_sig(S_DONE, 0); expect_sig(S_RDWE, 0);
                expect_sig(S_MREQ, 1); expect_sig(S_MWE, {31'b0, w});
                expect_sig(S_MADDR, a & ~32'd3);
                expect_sig(S_MBE, {28'b0, m_be(w, f3, a)});
                if (w) expect_sig(S_MWDATA, m_wdata(f3, d));
                if (k == 0 && pin_on) begin
                    pin("mem_addr", S_MADDR, p_addr);
                    pin("mem_be", S_MBE, {28'b0, p_be});
                    if (w) pin("mem_wdata", S_MWDATA, p_wdata);
                end
                step();
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        e = !(bus && acked);
        // response cycle; a new request and a stray ack here must both be ignored
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        expect_sig(S_BUSY, 0); expect_sig(S_DONE, 1); expect_sig(S_MREQ, 0);
        expect_sig(S_ERR, {31'b0, e}); expect_sig(S_MIS, {31'b0, mis});
        expect_sig(S_RDWE, {31'b0, (!w && !e)});
        if (bus && !w) expect_sig(S_RDATA, acked ? m_load(f3, a, rd) : 32'h0);
        if (pin_on && !w) pin("rdata_wb", S_RDATA, p_rdata);
        step();
        req_valid = 1'b0; mem_ack = 1'b0;
        expect_sig(S_BUSY, 0); expect_sig(S_DONE, 0); expect_sig(S_MREQ, 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int s = 0; s < NSIG; s++) exp_chk[s] = 1'b0;
        pin_cnt = 0;
        step();
        // after a reset edge: everything cleared
        for (int s = 0; s < NSIG; s++) expect_sig(s, 32'h0);
        step();
        reset = 1'b0;
        expect_sig(S_BUSY, 0); expect_sig(S_DONE, 0); expect_sig(S_MREQ, 0);
        step();

        // stores
        txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 1'b1,
            32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        txn(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 0, 32'h0, 1'b1,
            32'h0000_0300, 4'b0010, 32'hABAB_ABAB, 32'h0);
        txn(1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 1, 32'h0, 1'b1,
            32'h0000_0300, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        txn(1'b1, 3'b001, 32'h0000_0300, 32'h0000_5A5A, 0, 32'h0, 1'b1,
            32'h0000_0300, 4'b0011, 32'h5A5A_5A5A, 32'h0);
        txn(1'b1, 3'b000, 32'h0000_0302, 32'h0000_0077, 2, 32'h0, 1'b0, 0, 0, 0, 0);

        // loads
        txn(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'h0000_0080);
        txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 0, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'h0000_80FF);
        txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 1, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'hFFFF_80FF);
        txn(1'b0, 3'b001, 32'h0000_0200, 32'h0, 0, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'h0000_1234);
        txn(1'b0, 3'b010, 32'h0000_0204, 32'h0, 2, 32'h1234_5678, 1'b1,
            32'h0000_0204, 4'b1111, 32'h0, 32'h1234_5678);
        txn(1'b0, 3'b000, 32'h0000_0201, 32'h0, 0, 32'h0000_7F00, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'h0000_007F);

        // timeout: ack withheld, then ack exactly on the last allowed cycle
        txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, -1, 32'h0, 1'b1,
            32'h0000_0500, 4'b1111, 32'h0, 32'h0000_0000);
        txn(1'b0, 3'b010, 32'h0000_0504, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b1,
            32'h0000_0504, 4'b1111, 32'h0, 32'hCAFE_F00D);
        txn(1'b1, 3'b010, 32'h0000_0508, 32'h0102_0304, -1, 32'h0, 1'b0, 0, 0, 0, 0);

        // illegal funct3 codes
        txn(1'b0, 3'b011, 32'h0000_0600, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        txn(1'b1, 3'b100, 32'h0000_0604, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        txn(1'b0, 3'b111, 32'h0000_0608, 32'h0, 0, 32'h0, 1'b0, 0, 0, 0, 0);

        // reset in the middle of an ACCESS
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; mem_ack = 1'b0;
        expect_sig(S_BUSY, 1);
        step();
        req_valid = 1'b0;
        expect_sig(S_BUSY, 1); expect_sig(S_MREQ, 1);
        step();
        reset = 1'b1;
        expect_sig(S_BUSY, 1); expect_sig(S_MREQ, 1); expect_sig(S_DONE, 0);
        step();
        reset = 1'b0;
        for (int s = 0; s < NSIG; s++) expect_sig(s, 32'h0);
        step();
        expect_sig(S_DONE, 0); expect_sig(S_BUSY, 0); expect_sig(S_MREQ, 0);
        step();
        txn(1'b0, 3'b100, 32'h0000_0402, 32'h0, 0, 32'h00C3_0000, 1'b1,
            32'h0000_0400, 4'b1111, 32'h0, 32'h0000_00C3);

        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h1122_3344, 1'b0, 0, 0, 0, 0);
        txn(1'b1, 3'b001, 32'h0000_0301, 32'h0000_ABCD, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        txn(1'b0, 3'b101, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b0, 0, 0, 0, 0);
`else
        txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h1122_3344, 1'b1,
            32'h0000_0100, 4'b1111, 32'h0, 32'h1122_3344);
        txn(1'b1, 3'b001, 32'h0000_0301, 32'h0000_ABCD, 0, 32'h0, 1'b1,
            32'h0000_0300, 4'b0011, 32'hABCD_ABCD, 32'h0);
        txn(1'b0, 3'b101, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b1,
            32'h0000_0200, 4'b1111, 32'h0, 32'h0000_80FF);
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
